// File: rtl/dtpu_out_stream.sv
// dtpu_out_stream: output stage of the Cogitantium core. Buffers result
// words from the core's output-FIFO write port in a small circular FIFO and
// replays them as an AXI4-Stream master, framing them with TLAST according
// to a software-programmed frame length. Also exposes debug status: buffer
// level, completed-frame count and a sticky overflow flag.

module dtpu_out_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [DATA_WIDTH-1:0]      outfifo_din,
    input  logic                       outfifo_write,
    output logic                       outfifo_full_n,
    input  logic [LEN_WIDTH-1:0]       frame_len,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     level,
    output logic [LEN_WIDTH-1:0]       frame_cnt,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_countNext;
    logic                  r_fullN;
    logic                  r_overflow;

    logic [0:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_lenQ;
    logic [LEN_WIDTH-1:0]  r_beatCnt;
    logic [LEN_WIDTH-1:0]  r_frameCnt;
    logic [LEN_WIDTH-1:0]  w_lenLoad;

    logic                  w_wrAccept;
    logic                  w_rdAccept;
    logic                  w_tvalid;
    logic                  w_tlast;

    // A write is only taken when the registered full_n said there was room,
    // so a read in the same cycle as a full buffer never frees space for it.
    assign w_wrAccept = outfifo_write & r_fullN;
    assign w_tvalid   = (r_count != '0);
    assign w_rdAccept = w_tvalid & m_axis_tready;

    // A programmed length of zero is treated as single-beat frames.
    assign w_lenLoad  = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
    assign w_tlast    = w_tvalid & (r_beatCnt == (r_lenQ - LEN_WIDTH'(1)));

    assign outfifo_full_n = r_fullN;
    assign m_axis_tdata   = r_mem[r_rdPtr];
    assign m_axis_tkeep   = '1;
    assign m_axis_tvalid  = w_tvalid;
    assign m_axis_tlast   = w_tlast;
    assign level          = r_count;
    assign frame_cnt      = r_frameCnt;
    assign overflow       = r_overflow;

    // Next occupancy, used both for the count register and for full_n.
    always_comb begin
        w_countNext = r_count;
        if (w_wrAccept && !w_rdAccept) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_wrAccept && w_rdAccept) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // Storage array; deliberately not reset, stale words are never visible
    // because tvalid is derived from the count.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= outfifo_din;
        end
    end

    // Pointers, occupancy, registered full_n and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_fullN    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
            end
            r_count <= w_countNext;
            r_fullN <= (w_countNext != CNT_W'(DEPTH));
            if (outfifo_write && !r_fullN) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Frame tracker: counts beats per frame, reloads the length only while
    // idle with nothing pending so TLAST of a waiting beat never changes.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_lenQ     <= LEN_WIDTH'(1);
            r_beatCnt  <= '0;
            r_frameCnt <= '0;
        end else begin
            if (r_state == ST_IDLE && !w_tvalid) begin
                r_lenQ <= w_lenLoad;
            end
            if (w_rdAccept) begin
                if (w_tlast) begin
                    r_state    <= ST_IDLE;
                    r_beatCnt  <= '0;
                    r_frameCnt <= r_frameCnt + LEN_WIDTH'(1);
                end else begin
                    r_state   <= ST_ACTIVE;
                    r_beatCnt <= r_beatCnt + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dtpu_out_stream.sv
// Directed testbench for dtpu_out_stream with default parameters
// (64-bit data, 16-deep buffer, 16-bit frame fields). Inputs are driven and
// outputs sampled 1 ns after each rising clock edge.

module tb_dtpu_out_stream;

    localparam int DW = 64;
    localparam int DP = 16;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [DW-1:0]   outfifo_din;
    logic            outfifo_write;
    logic            outfifo_full_n;
    logic [LW-1:0]   frame_len;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [4:0]      level;
    logic [LW-1:0]   frame_cnt;
    logic            overflow;

    int nTests = 0;
    int nFail  = 0;

    dtpu_out_stream #(.DATA_WIDTH(DW), .DEPTH(DP), .LEN_WIDTH(LW)) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .outfifo_din    (outfifo_din),
        .outfifo_write  (outfifo_write),
        .outfifo_full_n (outfifo_full_n),
        .frame_len      (frame_len),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .level          (level),
        .frame_cnt      (frame_cnt),
        .overflow       (overflow)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; outfifo_write = 1'b0; outfifo_din = '0;
        m_axis_tready = 1'b0; frame_len = 16'd4;
        step(); step();
        nTests++; if (m_axis_tvalid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tvalid got %0b exp 0", m_axis_tvalid); end
        nTests++; if (m_axis_tlast !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tlast got %0b exp 0", m_axis_tlast); end
        nTests++; if (level !== 5'd0) begin nFail++; $display("[TB] FAIL reset_level got %0d exp 0", level); end
        nTests++; if (outfifo_full_n !== 1'b0) begin nFail++; $display("[TB] FAIL reset_full_n got %0b exp 0", outfifo_full_n); end
        nTests++; if (frame_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        nTests++; if (overflow !== 1'b0) begin nFail++; $display("[TB] FAIL reset_overflow got %0b exp 0", overflow); end
        nTests++; if (m_axis_tkeep !== 8'hFF) begin nFail++; $display("[TB] FAIL tkeep got %h exp ff", m_axis_tkeep); end
        aresetn = 1'b1;
        step();
        nTests++; if (outfifo_full_n !== 1'b1) begin nFail++; $display("[TB] FAIL release_full_n got %0b exp 1", outfifo_full_n); end
    endtask

    task automatic test_basic_frame();
        frame_len = 16'd4; m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(i);
            step();
            nTests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(i)) begin nFail++; $display("[TB] FAIL basic_data[%0d] got v=%0b d=%h exp v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, DW'(i)); end
            nTests++; if (m_axis_tlast !== (i == 3)) begin nFail++; $display("[TB] FAIL basic_tlast[%0d] got %0b exp %0b", i, m_axis_tlast, (i == 3)); end
            nTests++; if (level !== 5'd1) begin nFail++; $display("[TB] FAIL basic_level[%0d] got %0d exp 1", i, level); end
        end
        outfifo_write = 1'b0;
        step();
        nTests++; if (level !== 5'd0 || m_axis_tvalid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_drain got level=%0d v=%0b exp 0/0", level, m_axis_tvalid); end
        nTests++; if (frame_cnt !== 16'd1) begin nFail++; $display("[TB] FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_backpressure();
        m_axis_tready = 1'b0; frame_len = 16'd4;
        for (int i = 0; i < 17; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h100 + i);
            step();
            if (i == 15) begin
                nTests++; if (level !== 5'd16) begin nFail++; $display("[TB] FAIL fill_level16 got %0d exp 16", level); end
                nTests++; if (outfifo_full_n !== 1'b0) begin nFail++; $display("[TB] FAIL fill_full_n got %0b exp 0", outfifo_full_n); end
                nTests++; if (overflow !== 1'b0) begin nFail++; $display("[TB] FAIL fill_no_overflow got %0b exp 0", overflow); end
            end
        end
        nTests++; if (overflow !== 1'b1) begin nFail++; $display("[TB] FAIL drop_overflow got %0b exp 1", overflow); end
        nTests++; if (level !== 5'd16) begin nFail++; $display("[TB] FAIL drop_level got %0d exp 16", level); end
        outfifo_write = 1'b0; m_axis_tready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            nTests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(32'h100 + j)) begin nFail++; $display("[TB] FAIL bp_data[%0d] got v=%0b d=%h exp v=1 d=%h", j, m_axis_tvalid, m_axis_tdata, DW'(32'h100 + j)); end
            nTests++; if (m_axis_tlast !== ((j % 4) == 3)) begin nFail++; $display("[TB] FAIL bp_tlast[%0d] got %0b exp %0b", j, m_axis_tlast, ((j % 4) == 3)); end
            step();
            if (j == 0) begin
                nTests++; if (outfifo_full_n !== 1'b1) begin nFail++; $display("[TB] FAIL bp_full_n_rise got %0b exp 1", outfifo_full_n); end
            end
        end
        nTests++; if (level !== 5'd0 || m_axis_tvalid !== 1'b0) begin nFail++; $display("[TB] FAIL bp_drain got level=%0d v=%0b exp 0/0", level, m_axis_tvalid); end
        nTests++; if (frame_cnt !== 16'd5) begin nFail++; $display("[TB] FAIL bp_frame_cnt got %0d exp 5", frame_cnt); end
    endtask

    task automatic test_stable_tlast();
        int idx;
        frame_len = 16'd3; m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h200 + i);
            step();
        end
        outfifo_write = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            m_axis_tready = (c % 2) == 1;
            nTests++; if (m_axis_tdata !== DW'(32'h200 + idx) || m_axis_tlast !== (idx == 2)) begin nFail++; $display("[TB] FAIL stable[%0d] got d=%h l=%0b exp d=%h l=%0b", c, m_axis_tdata, m_axis_tlast, DW'(32'h200 + idx), (idx == 2)); end
            if (m_axis_tready) idx++;
            step();
        end
        m_axis_tready = 1'b0;
        nTests++; if (level !== 5'd0 || frame_cnt !== 16'd6) begin nFail++; $display("[TB] FAIL stable_end got level=%0d fc=%0d exp 0/6", level, frame_cnt); end
    endtask

    task automatic test_len_zero();
        frame_len = 16'd0; m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h250 + i);
            step();
            nTests++; if (m_axis_tlast !== 1'b1 || m_axis_tdata !== DW'(32'h250 + i)) begin nFail++; $display("[TB] FAIL len0_beat[%0d] got l=%0b d=%h exp l=1 d=%h", i, m_axis_tlast, m_axis_tdata, DW'(32'h250 + i)); end
            nTests++; if (frame_cnt !== LW'(6 + i)) begin nFail++; $display("[TB] FAIL len0_fc[%0d] got %0d exp %0d", i, frame_cnt, 6 + i); end
        end
        outfifo_write = 1'b0;
        step();
        nTests++; if (frame_cnt !== 16'd9) begin nFail++; $display("[TB] FAIL len0_fc_end got %0d exp 9", frame_cnt); end
    endtask

    task automatic test_len_change();
        frame_len = 16'd2; m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h300 + i);
            step();
        end
        outfifo_write = 1'b0;
        frame_len = 16'd5;
        step();
        m_axis_tready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            nTests++; if (m_axis_tdata !== DW'(32'h300 + j) || m_axis_tlast !== ((j % 2) == 1)) begin nFail++; $display("[TB] FAIL lenchg_old[%0d] got d=%h l=%0b exp d=%h l=%0b", j, m_axis_tdata, m_axis_tlast, DW'(32'h300 + j), ((j % 2) == 1)); end
            step();
        end
        nTests++; if (frame_cnt !== 16'd11) begin nFail++; $display("[TB] FAIL lenchg_fc_old got %0d exp 11", frame_cnt); end
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h350 + i);
            step();
        end
        outfifo_write = 1'b0;
        m_axis_tready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            nTests++; if (m_axis_tdata !== DW'(32'h350 + j) || m_axis_tlast !== (j == 4)) begin nFail++; $display("[TB] FAIL lenchg_new[%0d] got d=%h l=%0b exp d=%h l=%0b", j, m_axis_tdata, m_axis_tlast, DW'(32'h350 + j), (j == 4)); end
            step();
        end
        nTests++; if (frame_cnt !== 16'd12) begin nFail++; $display("[TB] FAIL lenchg_fc_new got %0d exp 12", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        frame_len = 16'd8; m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h500 + i);
            step();
        end
        outfifo_write = 1'b0;
        nTests++; if (level !== 5'd1 || m_axis_tdata !== DW'(32'h503)) begin nFail++; $display("[TB] FAIL mid_pre got level=%0d d=%h exp 1/503", level, m_axis_tdata); end
        aresetn = 1'b0;
        step();
        nTests++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin nFail++; $display("[TB] FAIL mid_rst got v=%0b level=%0d exp 0/0", m_axis_tvalid, level); end
        nTests++; if (frame_cnt !== 16'd0 || outfifo_full_n !== 1'b0) begin nFail++; $display("[TB] FAIL mid_rst_fc got fc=%0d full_n=%0b exp 0/0", frame_cnt, outfifo_full_n); end
        nTests++; if (overflow !== 1'b0) begin nFail++; $display("[TB] FAIL mid_rst_overflow got %0b exp 0", overflow); end
        aresetn = 1'b1;
        step();
        nTests++; if (outfifo_full_n !== 1'b1) begin nFail++; $display("[TB] FAIL mid_release_full_n got %0b exp 1", outfifo_full_n); end
        for (int i = 0; i < 8; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h600 + i);
            step();
            nTests++; if (m_axis_tdata !== DW'(32'h600 + i) || m_axis_tlast !== (i == 7)) begin nFail++; $display("[TB] FAIL mid_new[%0d] got d=%h l=%0b exp d=%h l=%0b", i, m_axis_tdata, m_axis_tlast, DW'(32'h600 + i), (i == 7)); end
        end
        outfifo_write = 1'b0;
        step();
        nTests++; if (frame_cnt !== 16'd1) begin nFail++; $display("[TB] FAIL mid_new_fc got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_full_simul();
        frame_len = 16'd4; m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            outfifo_write = 1'b1; outfifo_din = DW'(32'h400 + i);
            step();
        end
        nTests++; if (level !== 5'd16 || overflow !== 1'b0) begin nFail++; $display("[TB] FAIL simul_pre got level=%0d ovf=%0b exp 16/0", level, overflow); end
        outfifo_din = DW'(32'h4FF); m_axis_tready = 1'b1;
        nTests++; if (m_axis_tdata !== DW'(32'h400)) begin nFail++; $display("[TB] FAIL simul_head got %h exp 400", m_axis_tdata); end
        step();
        outfifo_write = 1'b0;
        nTests++; if (level !== 5'd15 || overflow !== 1'b1) begin nFail++; $display("[TB] FAIL simul_post got level=%0d ovf=%0b exp 15/1", level, overflow); end
        nTests++; if (outfifo_full_n !== 1'b1) begin nFail++; $display("[TB] FAIL simul_full_n got %0b exp 1", outfifo_full_n); end
        for (int j = 1; j < 16; j++) begin
            nTests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(32'h400 + j)) begin nFail++; $display("[TB] FAIL simul_drain[%0d] got v=%0b d=%h exp v=1 d=%h", j, m_axis_tvalid, m_axis_tdata, DW'(32'h400 + j)); end
            step();
        end
        nTests++; if (level !== 5'd0 || m_axis_tvalid !== 1'b0) begin nFail++; $display("[TB] FAIL simul_empty got level=%0d v=%0b exp 0/0", level, m_axis_tvalid); end
    endtask

    // Scenario sequence; each task leaves the buffer empty for the next.
    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_stable_tlast();
        test_len_zero();
        test_len_change();
        test_reset_mid_frame();
        test_full_simul();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/dtpu_out_stream.md
# dtpu_out_stream

Output-side stage of the Cogitantium accelerator, directly downstream of the core's output-FIFO write port. It accepts result words from the core's acc_fifo_write interface (WR_DATA / WR_EN / FULL_N) and buffers them in a small FIFO. It then emits the words as an AXI4-Stream master toward the DMA, asserting TLAST at the end of each software-programmed frame. It also reports buffer level, completed-frame count and a sticky overflow flag for debug.

## Interface
Parameters:
- DATA_WIDTH, 64, width of the result word and of TDATA; must be a multiple of 8
- DEPTH, 16, buffer depth in words; power of two, minimum 2
- LEN_WIDTH, 16, width of the frame-length and frame-counter fields

Ports:
- clk  in  1  single clock for the whole block
- aresetn  in  1  reset, synchronous, active-low
- outfifo_din  in  DATA_WIDTH  result word from the core
- outfifo_write  in  1  write strobe from the core
- outfifo_full_n  out  1  1 = space available; drives the core's FULL_N input
- frame_len  in  LEN_WIDTH  beats per frame; quasi-static, written by software before cs_start
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tkeep  out  DATA_WIDTH/8  always all ones
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of the current frame
- level  out  $clog2(DEPTH)+1  number of words currently buffered
- frame_cnt  out  LEN_WIDTH  completed frames, wraps modulo 2^LEN_WIDTH
- overflow  out  1  sticky flag: a write was dropped

## Operation
- **Buffer.**
  - Circular memory of DEPTH words with wr_ptr, rd_ptr and a registered count (= level).
  - Write accepted iff outfifo_write=1 and outfifo_full_n=1 in the same cycle.
  - Read occurs on handshake (m_axis_tvalid & m_axis_tready).
  - Pointers wrap from DEPTH-1 to 0.
- **Flags.**
  - outfifo_full_n is registered, equal to (count_next != DEPTH).
  - m_axis_tvalid = (count != 0); m_axis_tdata = mem[rd_ptr].
  - No write-to-read bypass.
- **Simultaneous read and write.**
  - Both pointers advance and count is unchanged.
  - When the buffer is full, a same-cycle read does not make room for that cycle's write; the write is dropped.
- **Drop.** A write while outfifo_full_n=0 is discarded and overflow is set to 1. overflow clears only on reset.
- **Frame FSM, states IDLE and ACTIVE.**
  - len_q = registered frame length; a frame_len of 0 is loaded as 1.
  - In IDLE, len_q reloads from frame_len only on cycles with m_axis_tvalid=0. Otherwise it is held, so TLAST stays stable while a beat is pending.
  - beat_cnt counts handshakes within the current frame.
  - m_axis_tlast = m_axis_tvalid & (beat_cnt == len_q-1).
  - IDLE → ACTIVE on a handshake without tlast; beat_cnt becomes 1.
  - ACTIVE → IDLE on a handshake with tlast; beat_cnt becomes 0 and frame_cnt increments.
  - A handshake with tlast in IDLE (len_q=1) stays in IDLE and increments frame_cnt.
  - ACTIVE: beat_cnt increments on each non-last handshake and len_q is held.

## Timing
- **Reset** (aresetn=0 at a clk edge):
  - count, pointers, beat_cnt and frame_cnt go to 0; overflow goes to 0; state goes to IDLE; len_q goes to 1.
  - m_axis_tvalid=0, m_axis_tlast=0, level=0.
  - outfifo_full_n=0 while in reset, and 1 on the first edge with aresetn=1.
  - Reset mid-frame discards all buffered data with no TLAST emitted.
  - Memory contents are not reset.
- **Latency.** A word written at edge N is visible on m_axis_tdata with m_axis_tvalid=1 after edge N, i.e. one cycle.
- **Throughput.** One word per cycle in and out simultaneously, sustained.
- **AXI-Stream rules.**
  - Once m_axis_tvalid=1, tdata and tlast are stable until the handshake.
  - tvalid does not depend combinationally on tready.
- **Full.** outfifo_full_n falls on the edge where count reaches DEPTH. It rises on the edge after the first read from full.
- **Wrap.** frame_cnt wraps from 2^LEN_WIDTH-1 to 0 without side effects.

## Test plan
- **Basic frame.** frame_len=4, DEPTH=16, tready=1; write 0x0..0x3 on consecutive cycles → 4 beats appear one cycle after each write; tlast only on 0x3; frame_cnt=1; level returns to 0.
- **Backpressure and fill.** tready=0; write 17 words → full_n=0 after the 16th; the 17th is dropped and overflow=1; level=16. Then release tready → exactly 16 words in original order; full_n=1 the cycle after the first read.
- **Stable tlast under backpressure.** frame_len=3; write 3 words, tready=0; then toggle tready every cycle → tdata and tlast are held while tready=0; tlast is asserted only with word 3.
- **Length of 0/1 and mid-stream change.**
  - frame_len=0: each beat carries tlast and frame_cnt increments per beat.
  - Change frame_len from 2 to 5 while words are pending: the new length applies only after the buffer drains in IDLE.
- **Simultaneous read/write when full.** DEPTH full and tready=1 with outfifo_write=1 in the same cycle → the read completes, the write is dropped, overflow=1, and level=15 afterwards.
- **Reset mid-frame.** frame_len=8; after 3 beats pulse aresetn=0 for one cycle → tvalid=0, level=0, frame_cnt=0, full_n=0 during reset and 1 the next cycle. A new 8-beat frame then ends with tlast on its 8th beat.
